// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : ALU operation codes and opcode classification helper      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_BEQ   = 4'b1010,
    ALU_BNE   = 4'b1011,
    ALU_BLT   = 4'b1100,
    ALU_BGE   = 4'b1101,
    ALU_PASSB = 4'b1110,
    ALU_RSVD  = 4'b1111
  } alu_op_t;

  function automatic logic is_branch_op(input alu_op_t op);
    return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) || (op == ALU_BGE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +--------------------------------------------------------------------+
// | alu_core : combinational ALU, result plus branch condition flag     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            cond
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // cond is meaningful only for the four branch ops; it stays 0 otherwise.
  always_comb begin
    result = '0;
    cond   = 1'b0;
    unique case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SUB:   result = a - b;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   result = XLEN'(lt_s);
      ALU_SLTU:  result = XLEN'(lt_u);
      ALU_BEQ: begin
        cond   = (a == b);
        result = XLEN'(cond);
      end
      ALU_BNE: begin
        cond   = (a != b);
        result = XLEN'(cond);
      end
      ALU_BLT: begin
        cond   = lt_s;
        result = XLEN'(cond);
      end
      ALU_BGE: begin
        cond   = !lt_s;
        result = XLEN'(cond);
      end
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// +--------------------------------------------------------------------+
// | ex_stage : execute stage with EX/MEM register, redirect, counters   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             alu_src_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic [4:0]       rd_i,
  input  logic             reg_write_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             flush_i,
  input  logic             mem_ready_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_result_o,
  output logic [XLEN-1:0]  ex_store_data_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  alu_op_t         op;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_cond;
  logic            branch_taken;
  logic            taken;
  logic            capture;
  logic            stall;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;

  assign op   = alu_op_t'(op_i);
  assign op_b = alu_src_i ? imm_i : rs2_data_i;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu (
    .op     (op),
    .a      (rs1_data_i),
    .b      (op_b),
    .result (alu_result),
    .cond   (alu_cond)
  );

  // A conditional branch carrying a non-branch op never redirects.
  assign branch_taken = is_branch_i && is_branch_op(op) && alu_cond;
  assign taken        = branch_taken || is_jal_i;

  assign stall      = ex_valid_o && !mem_ready_i;
  assign id_ready_o = !stall;
  assign capture    = id_valid_i && id_ready_o && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_o      <= 1'b0;
      ex_result_o     <= '0;
      ex_store_data_o <= '0;
      ex_rd_o         <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      redirect_o      <= 1'b0;
      redirect_pc_o   <= '0;
      branch_cnt_o    <= '0;
      taken_cnt_o     <= '0;
    end else begin
      // Redirect is a single pulse aligned with the first valid cycle.
      redirect_o <= capture && taken;
      if (capture) begin
        ex_valid_o      <= 1'b1;
        ex_result_o     <= is_jal_i ? (pc_i + PC_STEP) : alu_result;
        ex_store_data_o <= rs2_data_i;
        ex_rd_o         <= rd_i;
        reg_write_q     <= reg_write_i;
        mem_read_q      <= mem_read_i;
        mem_write_q     <= mem_write_i;
        redirect_pc_o   <= pc_i + imm_i;
        if (is_branch_i) begin
          branch_cnt_o <= branch_cnt_o + 1'b1;
          if (branch_taken) begin
            taken_cnt_o <= taken_cnt_o + 1'b1;
          end
        end
      end else if (flush_i || !stall) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

  assign ex_reg_write_o = reg_write_q && ex_valid_o;
  assign ex_mem_read_o  = mem_read_q  && ex_valid_o;
  assign ex_mem_write_o = mem_write_q && ex_valid_o;

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RISC-V pipeline, directly downstream of the ALU control decode. Consumes the 4-bit ALU operation code plus ID/EX operands.
- Computes the ALU result and resolves branches/JAL, then holds everything in the EX/MEM pipeline register under a valid/ready handshake with the MEM stage.
- Issues a one-cycle fetch redirect for taken control transfers and keeps branch statistics counters.

Parameters:
XLEN, 32, datapath width; shift amount is operand B[$clog2(XLEN)-1:0]
CNT_W, 32, width of branch statistics counters

Ports:
clk  in  1  clock, all state rises on posedge
reset  in  1  asynchronous, active-high reset
id_valid_i  in  1  ID/EX holds a valid instruction
id_ready_o  out  1  stage can accept an instruction this cycle
op_i  in  4  ALU operation code (alu_pkg encoding)
rs1_data_i  in  XLEN  operand A
rs2_data_i  in  XLEN  register operand B / store data
imm_i  in  XLEN  sign-extended immediate
alu_src_i  in  1  1: operand B = imm_i, 0: rs2_data_i
pc_i  in  XLEN  instruction PC
is_branch_i  in  1  conditional branch
is_jal_i  in  1  JAL
rd_i  in  5  destination register
reg_write_i, mem_read_i, mem_write_i  in  1 each  control passthrough
flush_i  in  1  kill instruction entering/held in stage (hazard unit)
mem_ready_i  in  1  MEM stage accepts EX/MEM contents
ex_valid_o  out  1  EX/MEM register valid
ex_result_o  out  XLEN  ALU result (PC+4 for JAL)
ex_store_data_o  out  XLEN  registered rs2_data_i
ex_rd_o  out  5  registered rd
ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  out  1 each  registered controls, gated by ex_valid_o
redirect_o  out  1  one-cycle fetch redirect pulse
redirect_pc_o  out  XLEN  target = pc_i + imm_i
branch_cnt_o  out  CNT_W  resolved conditional branches
taken_cnt_o  out  CNT_W  taken conditional branches

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All registers and outputs reset to 0: ex_valid_o=0, redirect_o=0, counters=0.
- Handshake:
  - id_ready_o = !ex_valid_o || mem_ready_i (combinational).
  - Capture when id_valid_i && id_ready_o && !flush_i. ex_valid_o=1 the next cycle; latency 1.
  - Hold all registered outputs unchanged while ex_valid_o && !mem_ready_i.
  - Drain (ex_valid_o -> 0) when mem_ready_i and no new capture.
- Flush:
  - flush_i=1 clears ex_valid_o next cycle and blocks capture, including while stalled.
  - A flush also suppresses a redirect not yet issued.
- ALU operation encoding (B = selected operand):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 SLT signed, 1001 SLTU, 1010 BEQ, 1011 BNE, 1100 BLT, 1101 BGE, 1110 PASSB (LUI).
  - 1111 reserved, result 0.
  - Add/sub wrap modulo 2^XLEN. SRA is arithmetic.
  - Branch ops produce result 1/0 = condition. BLT/BGE compare signed.
- Control transfer:
  - taken = is_branch_i && condition, or is_jal_i.
  - On capture with taken: redirect_o=1 for exactly one cycle (the first ex_valid cycle), even if the stage then stalls; redirect_pc_o is registered.
  - JAL result = pc_i+4.
  - is_branch_i with a non-branch op: not taken.
- Counters:
  - On capture of an is_branch_i instruction: branch_cnt_o+1; taken_cnt_o+1 if taken.
  - Counters wrap at 2^CNT_W. Flushed and never-captured instructions are not counted.
- Reset mid-stall or mid-redirect: everything clears immediately (async); no pulse survives.

Decomposition:
- alu_pkg: alu_op_t enum holding the 4-bit operation codes above, plus the is_branch_op() helper function.
- Sub-module alu_core: purely combinational op/A/B -> result, cond. ex_stage owns the pipeline register, redirect logic and counters.

Test Plan:
- ADD rs1=0x7FFFFFFF, imm=1, alu_src=1 -> next cycle ex_valid_o=1, ex_result_o=0x80000000; SRA 0x80000000 by 4 -> 0xF8000000.
- BEQ rs1=rs2=5, pc=0x100, imm=0x20 -> redirect_o high one cycle, redirect_pc_o=0x120, branch_cnt=1, taken_cnt=1; BNE same operands -> no redirect, branch_cnt=2, taken_cnt=1.
- mem_ready_i=0 for 3 cycles after capture of a taken JAL (pc=0x40) -> outputs held, ex_result_o=0x44, redirect_o high only first cycle, id_ready_o=0 throughout.
- flush_i with id_valid_i=1 and a taken branch -> ex_valid_o=0, no redirect, counters unchanged.
- reset asserted while stalled with ex_valid_o=1 -> all outputs 0 asynchronously, id_ready_o=1.
- SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0; op 1111 -> 0.
